boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/hack_pkg.sv | 22 ++
 rtl/byte_pair.sv | 25 ++
 rtl/boot_loader.sv | 143 ++++++++++++++
 tb/tb_boot_loader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack computer: loader FSM states, ROM geometry
// and the 16-bit instruction word type.
package hack_pkg;

    localparam int ROM_AW    = 15;
    localparam int MAX_WORDS = 32768;

    typedef logic [15:0] word_t;

    typedef enum logic [3:0] {
        HDR_HI,
        HDR_LO,
        DAT_HI,
        DAT_LO,
        WRITE,
        CS_HI,
        CS_LO,
        RUN,
        ERROR
    } boot_state_t;

endpackage

// File: rtl/byte_pair.sv
// Assembles two consecutive bytes into a big-endian 16-bit word; the high byte
// is latched and the low byte is taken straight from the incoming stream.
module byte_pair
    import hack_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load_hi,
    input  logic [7:0] data_byte,
    output word_t      word
);

    logic [7:0] hi_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= 8'h00;
        end else if (load_hi) begin
            hi_q <= data_byte;
        end
    end

    assign word = {hi_q, data_byte};

endmodule

// File: rtl/boot_loader.sv
// Streams a length-prefixed, checksummed image into the instruction ROM and
// releases the CPU from reset once the image has been verified.
module boot_loader
    import hack_pkg::*;
#(
    parameter int ROM_AW    = hack_pkg::ROM_AW,
    parameter int MAX_WORDS = hack_pkg::MAX_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              rx_ready,
    input  logic              reload,
    output logic              rom_we,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [15:0]       rom_data,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    localparam int IDX_W = 17;
    localparam logic [IDX_W-1:0] MAX_N = IDX_W'(MAX_WORDS);

    boot_state_t       state_q, state_d;
    logic [IDX_W-1:0]  index_q;
    word_t             count_q;
    word_t             sum_q;
    logic [ROM_AW-1:0] rom_addr_q;
    word_t             rom_data_q;

    logic  accept;
    logic  load_hi;
    word_t pair_word;

    assign accept  = rx_valid && rx_ready;
    assign load_hi = accept && (state_q == HDR_HI || state_q == DAT_HI || state_q == CS_HI);

    byte_pair u_byte_pair (
        .clk      (clk),
        .reset    (reset),
        .load_hi  (load_hi),
        .data_byte(rx_byte),
        .word     (pair_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HDR_HI;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR_HI: if (accept) state_d = HDR_LO;
            HDR_LO: begin
                if (accept) begin
                    if (pair_word == 16'h0000) begin
                        state_d = CS_HI;
                    end else if ({1'b0, pair_word} > MAX_N) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DAT_HI;
                    end
                end
            end
            DAT_HI: if (accept) state_d = DAT_LO;
            DAT_LO: if (accept) state_d = WRITE;
            // index_q still counts the words written before this one
            WRITE: begin
                if ((index_q + 1'b1) < {1'b0, count_q}) begin
                    state_d = DAT_HI;
                end else begin
                    state_d = CS_HI;
                end
            end
            CS_HI: if (accept) state_d = CS_LO;
            CS_LO: begin
                if (accept) begin
                    state_d = (pair_word == sum_q) ? RUN : ERROR;
                end
            end
            RUN:   if (reload) state_d = HDR_HI;
            ERROR: state_d = ERROR;
            default: state_d = ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            index_q    <= '0;
            count_q    <= '0;
            sum_q      <= '0;
            rom_addr_q <= '0;
            rom_data_q <= '0;
        end else begin
            case (state_q)
                HDR_LO: if (accept) count_q <= pair_word;
                DAT_LO: begin
                    if (accept) begin
                        rom_addr_q <= index_q[ROM_AW-1:0];
                        rom_data_q <= pair_word;
                        sum_q      <= sum_q + pair_word;
                    end
                end
                WRITE: index_q <= index_q + 1'b1;
                RUN: begin
                    if (reload) begin
                        index_q <= '0;
                        sum_q   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rx_ready  = 1'b0;
        rom_we    = 1'b0;
        cpu_reset = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        case (state_q)
            HDR_HI, HDR_LO, DAT_HI, DAT_LO, CS_HI, CS_LO: rx_ready = 1'b1;
            WRITE: rom_we = 1'b1;
            RUN: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
            end
            ERROR: error = 1'b1;
            default: ;
        endcase
    end

    assign rom_addr = rom_addr_q;
    assign rom_data = rom_data_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: a byte-by-byte vector table for the reference
// stream plus hand-written sequences for errors, gaps, reload and mid-load reset.
module tb_boot_loader;
    import hack_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_ready;
    logic        reload;
    logic        rom_we;
    logic [14:0] rom_addr;
    logic [15:0] rom_data;
    logic        cpu_reset;
    logic        done;
    logic        error;

    boot_loader dut (
        .clk      (clk),
        .reset    (reset),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .rx_ready (rx_ready),
        .reload   (reload),
        .rom_we   (rom_we),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .cpu_reset(cpu_reset),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  rx_byte;
        logic        ready;
        logic        we;
        logic [14:0] addr;
        logic [15:0] data;
        logic        cpu_rst;
        logic        dn;
        logic        er;
    } vec_t;

    typedef struct {
        logic [14:0] addr;
        logic [15:0] data;
    } wr_t;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] img [0:127];
    wr_t         writes[$];
    int          done_cycles = 0;
    int          overlap     = 0;

    // Observe the ROM port and status away from the active edge
    always @(negedge clk) begin
        if (rom_we) writes.push_back('{rom_addr, rom_data});
        if (done) done_cycles++;
        if (rom_we && rx_ready) overlap++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [39:0] pack_out(input logic rdy, input logic we,
                                             input logic [14:0] addr, input logic [15:0] data,
                                             input logic cpu, input logic dn, input logic er);
        return {4'b0, rdy, we, addr, data, cpu, dn, er};
    endfunction

    task automatic check_output(input string name, input logic [39:0] exp);
        logic [39:0] act;
        act = pack_out(rx_ready, rom_we, rom_addr, rom_data, cpu_reset, done, error);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual rdy/we/addr/data/cpu/done/err=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_value(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reload   = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Offer one byte and return #1 after the edge that accepted it
    task automatic apply_stimulus(input logic [7:0] b);
        int waited;
        waited   = 0;
        rx_valid = 1'b1;
        rx_byte  = b;
        while (!rx_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!rx_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL byte_accept_timeout actual=rx_ready0 required=rx_ready1");
        end else begin
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_gapped(input logic [7:0] b, input int gap_pct);
        if (int'($urandom_range(99)) < gap_pct) begin
            rx_valid = 1'b0;
            @(posedge clk); #1;
        end
        apply_stimulus(b);
    endtask

    // Sends img[0..n-1] with header and checksum, checking each write's timing
    task automatic send_image(input int n, input int gap_pct, input string tag);
        logic [15:0] sum;
        logic [15:0] nw;
        sum = 16'h0000;
        nw  = 16'(n);
        for (int i = 0; i < n; i++) sum = sum + img[i];
        send_gapped(nw[15:8], gap_pct);
        send_gapped(nw[7:0], gap_pct);
        for (int i = 0; i < n; i++) begin
            send_gapped(img[i][15:8], gap_pct);
            send_gapped(img[i][7:0], gap_pct);
            check_output($sformatf("%s_write%0d", tag, i),
                         pack_out(1'b0, 1'b1, 15'(i), img[i], 1'b1, 1'b0, 1'b0));
        end
        send_gapped(sum[15:8], gap_pct);
        send_gapped(sum[7:0], gap_pct);
        check_output({tag, "_run"},
                     pack_out(1'b0, 1'b0, 15'(n - 1), img[n - 1], 1'b0, 1'b1, 1'b0));
    endtask

    initial begin
        vec_t vecs[8];
        int   base;
        int   done_base;

        vecs[0] = '{8'h00, 1, 0, 15'd0, 16'h0000, 1, 0, 0};
        vecs[1] = '{8'h02, 1, 0, 15'd0, 16'h0000, 1, 0, 0};
        vecs[2] = '{8'hEC, 1, 0, 15'd0, 16'h0000, 1, 0, 0};
        vecs[3] = '{8'h10, 0, 1, 15'd0, 16'hEC10, 1, 0, 0};
        vecs[4] = '{8'hE3, 1, 0, 15'd0, 16'hEC10, 1, 0, 0};
        vecs[5] = '{8'h08, 0, 1, 15'd1, 16'hE308, 1, 0, 0};
        vecs[6] = '{8'hCF, 1, 0, 15'd1, 16'hE308, 1, 0, 0};
        vecs[7] = '{8'h18, 0, 0, 15'd1, 16'hE308, 0, 1, 0};

        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        reload   = 1'b0;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_output("reset_state", pack_out(1, 0, 15'd0, 16'h0000, 1, 0, 0));

        // Reference two-word image, checked after every accepted byte
        base = writes.size();
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].rx_byte);
            check_output($sformatf("vec%0d", i),
                         pack_out(vecs[i].ready, vecs[i].we, vecs[i].addr, vecs[i].data,
                                  vecs[i].cpu_rst, vecs[i].dn, vecs[i].er));
        end
        check_value("ref_write_count", writes.size() - base, 2);
        if (writes.size() - base == 2) begin
            check_value("ref_write0", int'({writes[base].addr, writes[base].data}), int'({15'd0, 16'hEC10}));
            check_value("ref_write1", int'({writes[base+1].addr, writes[base+1].data}), int'({15'd1, 16'hE308}));
        end

        // Bad checksum lands in ERROR; reload there is ignored
        do_reset();
        done_base = done_cycles;
        apply_stimulus(8'h00); apply_stimulus(8'h02);
        apply_stimulus(8'hEC); apply_stimulus(8'h10);
        apply_stimulus(8'hE3); apply_stimulus(8'h08);
        apply_stimulus(8'hCF); apply_stimulus(8'h19);
        check_output("bad_cs_error", pack_out(0, 0, 15'd1, 16'hE308, 1, 0, 1));
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("error_ignores_reload", pack_out(0, 0, 15'd1, 16'hE308, 1, 0, 1));
        check_value("error_done_never", done_cycles - done_base, 0);

        // Empty image goes straight to RUN without touching the ROM
        do_reset();
        check_output("reset_after_error", pack_out(1, 0, 15'd0, 16'h0000, 1, 0, 0));
        base = writes.size();
        apply_stimulus(8'h00); apply_stimulus(8'h00);
        apply_stimulus(8'h00); apply_stimulus(8'h00);
        check_output("empty_image_run", pack_out(0, 0, 15'd0, 16'h0000, 0, 1, 0));
        check_value("empty_image_writes", writes.size() - base, 0);

        // Count one beyond the maximum is rejected right after the header
        do_reset();
        apply_stimulus(8'h80);
        check_output("oversize_hdr_hi", pack_out(1, 0, 15'd0, 16'h0000, 1, 0, 0));
        apply_stimulus(8'h01);
        check_output("oversize_error", pack_out(0, 0, 15'd0, 16'h0000, 1, 0, 1));

        // 100-word image with random idle gaps
        do_reset();
        for (int i = 0; i < 100; i++) img[i] = 16'(i * 16'h9E37 + 16'h1234);
        base = writes.size();
        overlap = 0;
        send_image(100, 30, "gap");
        check_value("gap_write_count", writes.size() - base, 100);
        check_value("gap_we_while_ready", overlap, 0);

        // Reload from RUN, then a second image starting at address 0
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        check_output("reload_next_cycle", pack_out(1, 0, 15'd99, img[99], 1, 0, 0));
        img[0] = 16'hA5A5;
        img[1] = 16'hFFFF;
        send_image(2, 0, "reload");

        // Reset after three words of a ten-word image, then a clean reload
        do_reset();
        for (int i = 0; i < 10; i++) img[i] = 16'(16'h0101 * (i + 1));
        apply_stimulus(8'h00); apply_stimulus(8'h0A);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(img[i][15:8]);
            apply_stimulus(img[i][7:0]);
        end
        check_output("midload_third_write", pack_out(0, 1, 15'd2, 16'h0303, 1, 0, 0));
        do_reset();
        check_output("midload_reset", pack_out(1, 0, 15'd0, 16'h0000, 1, 0, 0));
        send_image(10, 0, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
